// File: rtl/disp_pkg.sv
// Shared types and constants for the hex-display arbiter: state encoding,
// requester count/index width and payload width.
package disp_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned DATA_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic req_idx_t onehot_to_idx(input logic [N_REQ-1:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (oh[k]) idx = req_idx_t'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester-side and display-side signals of the display arbiter.
interface disp_arbiter_if;
    import disp_pkg::*;

    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic [N_REQ-1:0]        o_req_ready;
    logic [DATA_W-1:0]       o_disp_data;
    req_idx_t                o_owner;
    logic                    o_busy;

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_disp_data,
        output o_owner,
        output o_busy
    );

    modport master (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_disp_data,
        input  o_owner,
        input  o_busy
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick; priority starts just after the last grant.
module rr_arbiter4
    import disp_pkg::*;
(
    input  logic [3:0] req,
    input  req_idx_t   last,
    output logic [3:0] gnt
);

    req_idx_t cand;

    // Walk from lowest to highest priority so the nearest requester wins.
    always_comb begin
        gnt  = '0;
        cand = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = req_idx_t'(int'(last) + i);
            if (req[cand]) gnt = 4'(4'b0001 << cand);
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Shares one 4-digit hex display among four requesters; each accepted value
// is held on the display for HOLD_CYCLES cycles before the next grant.
module disp_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 50000
) (
    input logic           clk,
    input logic           rst,
    disp_arbiter_if.slave bus
);
    import disp_pkg::*;

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  disp_q, disp_d;
    req_idx_t           owner_q, owner_d;
    req_idx_t           last_q, last_d;
    logic               busy_q, busy_d;
    logic [N_REQ-1:0]   gnt_c;
    logic [N_REQ-1:0]   ready_c;

    rr_arbiter4 u_rr (
        .req  (bus.i_req_valid),
        .last (last_q),
        .gnt  (gnt_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        owner_d = owner_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ready_c = '0;
        case (state_q)
            ST_IDLE: begin
                // Ready is offered only in IDLE and never while reset is held.
                ready_c = rst ? '0 : gnt_c;
                if (|ready_c) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    busy_d  = 1'b1;
                    owner_d = onehot_to_idx(ready_c);
                    last_d  = onehot_to_idx(ready_c);
                    for (int k = 0; k < int'(N_REQ); k++) begin
                        if (ready_c[k]) disp_d = bus.i_req_data[k*DATA_W +: DATA_W];
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // last_q resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            disp_q  <= '0;
            owner_q <= '0;
            last_q  <= req_idx_t'(N_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_req_ready = ready_c;
    assign bus.o_disp_data = disp_q;
    assign bus.o_owner     = owner_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Randomized and directed bench for disp_arbiter against a transaction-level
// model (round-robin pick plus "display busy for H cycles after a grant").
module tb_disp_arbiter;
    import disp_pkg::*;

    localparam int unsigned H = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    disp_arbiter_if bus ();
    disp_arbiter_if bus1 ();

    disp_arbiter #(.N_REQ(4), .HOLD_CYCLES(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    disp_arbiter #(.N_REQ(4), .HOLD_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: cycles the display stays busy, last grant, shown value.
    int          m_left;
    logic [1:0]  m_last;
    logic [1:0]  m_owner;
    logic [15:0] m_disp;
    int          m_xfer;
    int          m_prev;
    int          m_gap;
    int          cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input logic [1:0] last);
        int idx;
        for (int i = 1; i <= 4; i++) begin
            idx = (int'(last) + i) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_last  = 2'd3;
        m_owner = 2'd0;
        m_disp  = 16'h0000;
        m_xfer  = -1;
        m_prev  = -100;
        m_gap   = 0;
    endtask

    // Apply inputs right after a falling edge, check ready, let one rising edge
    // pass, then check the registered outputs at the next falling edge.
    task automatic cycle(input logic [3:0] v, input logic [63:0] d);
        int p;
        logic [3:0] er;
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        #1;
        p  = (m_left == 0) ? rr_pick(v, m_last) : -1;
        er = (p >= 0) ? 4'(1 << p) : 4'b0000;
        check("ready", 64'(bus.o_req_ready), 64'(er));
        m_xfer = p;
        if (p >= 0) begin
            m_owner = 2'(p);
            m_last  = 2'(p);
            m_disp  = d[16*p +: 16];
            m_left  = H;
            m_gap   = cyc - m_prev;
            m_prev  = cyc;
        end else if (m_left > 0) begin
            m_left--;
        end
        cyc++;
        @(negedge clk);
        check("disp", 64'(bus.o_disp_data), 64'(m_disp));
        check("owner", 64'(bus.o_owner), 64'(m_owner));
        check("busy", 64'(bus.o_busy), 64'(m_left > 0));
    endtask

    logic [3:0]  cur_v;
    logic [63:0] cur_d;
    logic [63:0] fair_d;
    int          grants[$];

    initial begin
        cyc = 0;
        rst = 1'b1;
        model_reset();
        bus.i_req_valid  = 4'hF;
        bus.i_req_data   = '0;
        bus1.i_req_valid = 4'hF;
        bus1.i_req_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 64'(bus.o_req_ready), 64'h0);
        check("rst_disp", 64'(bus.o_disp_data), 64'h0);
        check("rst_owner", 64'(bus.o_owner), 64'h0);
        check("rst_busy", 64'(bus.o_busy), 64'h0);
        check("rst_ready_h1", 64'(bus1.o_req_ready), 64'h0);
        bus.i_req_valid  = 4'h0;
        bus1.i_req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        // HOLD_CYCLES=1: continuous requester 0 is granted every other cycle.
        bus1.i_req_valid = 4'b0001;
        bus1.i_req_data  = 64'h0000_0000_0000_A5A5;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("h1_ready", 64'(bus1.o_req_ready), (i % 2 == 0) ? 64'h1 : 64'h0);
            check("h1_busy", 64'(bus1.o_busy), (i % 2 == 1) ? 64'h1 : 64'h0);
            if (i > 0) check("h1_disp", 64'(bus1.o_disp_data), 64'hA5A5);
            @(negedge clk);
        end
        bus1.i_req_valid = 4'h0;

        // Single requester 1 with BEEF, kept valid: grants 5 cycles apart.
        cycle(4'b0010, 64'h0000_0000_BEEF_0000);
        check("single_disp", 64'(bus.o_disp_data), 64'hBEEF);
        check("single_owner", 64'(bus.o_owner), 64'h1);
        for (int i = 0; i < 5; i++) cycle(4'b0010, 64'h0000_0000_BEEF_0000);
        check("single_gap", 64'(m_gap), 64'(H + 1));
        for (int i = 0; i < 8; i++) cycle(4'b0000, 64'h0);

        // All four continuously valid: strict rotation, fixed spacing.
        fair_d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        grants.delete();
        for (int i = 0; i < 25; i++) begin
            cycle(4'hF, fair_d);
            if (m_xfer >= 0) begin
                check("fair_disp", 64'(bus.o_disp_data), 64'(16'h1111 * (m_xfer + 1)));
                if (grants.size() > 0) begin
                    check("fair_order", 64'(m_xfer), 64'((grants[grants.size()-1] + 1) % 4));
                    check("fair_gap", 64'(m_gap), 64'(H + 1));
                end
                grants.push_back(m_xfer);
            end
        end
        check("fair_count", 64'(grants.size()), 64'd5);
        for (int i = 0; i < 8; i++) cycle(4'b0000, 64'h0);

        // Late arrival: requester 2 rises during requester 0's hold.
        cycle(4'b0001, 64'h0000_3030_0000_1010);
        check("late_first", 64'(bus.o_owner), 64'h0);
        for (int i = 0; i < 4; i++) cycle(4'b0101, 64'h0000_3030_0000_1010);
        cycle(4'b0101, 64'h0000_3030_0000_1010);
        check("late_owner", 64'(bus.o_owner), 64'h2);
        check("late_disp", 64'(bus.o_disp_data), 64'h3030);
        for (int i = 0; i < 8; i++) cycle(4'b0000, 64'h0);

        // Withdrawn request: requester 3 pulses during hold, never transfers.
        cycle(4'b0001, 64'h0000_0000_0000_7777);
        cycle(4'b1000, 64'h9999_0000_0000_0000);
        for (int i = 0; i < 8; i++) cycle(4'b0000, 64'h0);
        check("wd_disp", 64'(bus.o_disp_data), 64'h7777);
        check("wd_owner", 64'(bus.o_owner), 64'h0);

        // Random traffic: valid may drop before ready, data stable while valid.
        cur_v = '0;
        cur_d = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (cur_v[k] && m_xfer != k) begin
                    if ($urandom_range(7) == 0) cur_v[k] = 1'b0;
                end else begin
                    cur_v[k] = ($urandom_range(1) == 1);
                    cur_d[16*k +: 16] = 16'($urandom);
                end
            end
            cycle(cur_v, cur_d);
        end

        // Reset asserted in the middle of a hold interval.
        for (int i = 0; i < 8; i++) cycle(4'b0000, 64'h0);
        cycle(4'hF, 64'h4444_3333_2222_1111);
        cycle(4'hF, 64'h4444_3333_2222_1111);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_disp", 64'(bus.o_disp_data), 64'h0);
        check("mid_rst_owner", 64'(bus.o_owner), 64'h0);
        check("mid_rst_busy", 64'(bus.o_busy), 64'h0);
        check("mid_rst_ready", 64'(bus.o_req_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(4'hF, 64'h4444_3333_2222_1111);
        check("post_rst_owner", 64'(bus.o_owner), 64'h0);
        check("post_rst_disp", 64'(bus.o_disp_data), 64'h1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the 4-digit hex display; fixed at 4 in this revision.
REQ-002 Parameter HOLD_CYCLES, default 50000: minimum number of clk cycles each accepted value stays on the display; legal range 1..2^20.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_req_valid  input  4  per-requester valid; bit k belongs to requester k.
REQ-006 i_req_data  input  64  per-requester 16-bit payload; requester k at bits [16k+15:16k].
REQ-007 o_req_ready  output  4  per-requester ready; at most one bit high in any cycle.
REQ-008 o_disp_data  output  16  value driven to the hex display datapath input; registered.
REQ-009 o_owner  output  2  index of the requester whose value is on o_disp_data; registered.
REQ-010 o_busy  output  1  high while a hold interval is running; registered.

Function
REQ-011 FSM states: IDLE and HOLD; there are no other states.
REQ-012 In IDLE, the block shall select one requester from those with i_req_valid high, using round-robin order starting at (last_grant+1) mod 4.
REQ-013 In IDLE, o_req_ready shall be the one-hot of the selected requester, combinationally from i_req_valid and last_grant; it is 0 if no valid is high.
REQ-014 A transfer occurs when i_req_valid[k] and o_req_ready[k] are both high on a rising edge.
REQ-015 On a transfer, the next cycle shall show: o_disp_data = payload k, o_owner = k, last_grant = k, o_busy = 1, state = HOLD; latency is exactly 1 cycle.
REQ-016 In HOLD, o_req_ready shall be 0 and a down-counter shall be loaded with HOLD_CYCLES-1 at transfer.
REQ-017 The counter decrements once per cycle; in the cycle it reads 0, the next state is IDLE and o_busy falls on that edge.
REQ-018 As a result, back-to-back transfers are spaced exactly HOLD_CYCLES+1 cycles apart when requests are continuous.
REQ-019 In IDLE with no valid high, state, o_disp_data and o_owner shall hold their values; the last value stays displayed.
REQ-020 A requester shall hold valid and data stable until its transfer; if valid drops before ready, no transfer occurs and no state is altered.
REQ-021 Valid rising during HOLD shall be ignored until IDLE; requests are never lost while valid stays high.
REQ-022 A requester that is continuously valid alone shall be granted every HOLD_CYCLES+1 cycles.
REQ-023 With all four continuously valid, grants shall rotate strictly 0,1,2,3,0,... with no starvation.
REQ-024 The counter width shall be $clog2(HOLD_CYCLES+1); when HOLD_CYCLES=1, HOLD lasts one cycle.

Reset
REQ-025 While rst is high, the block shall hold: state = IDLE, o_disp_data = 16'h0000, o_owner = 0, o_busy = 0, last_grant = 3 (so requester 0 has first priority), counter = 0.
REQ-026 o_req_ready shall be 0 while rst is high.
REQ-027 Reset asserted mid-HOLD shall abort the interval immediately (asynchronously); on release, the FSM starts in IDLE.

Structure
REQ-028 A shared package/header disp_pkg shall hold the FSM state encoding, N_REQ, and the requester-index width.
REQ-029 One sub-module, rr_arbiter4, shall implement the combinational 4-way round-robin pick (inputs req[3:0], last[1:0]; output gnt one-hot).
REQ-030 o_disp_data shall connect directly to i_data of the hex display driver at top level.

Verification (HOLD_CYCLES=4 unless noted)
REQ-031 Reset: assert rst mid-cycle with all valid high -> outputs immediately 0, o_req_ready = 0; first grant after release goes to requester 0.
REQ-032 Single requester: req1 valid with data 16'hBEEF -> o_req_ready = 4'b0010 for one cycle; next cycle o_disp_data = BEEF, o_owner = 1, o_busy = 1 for 4 cycles; next ready 5 cycles after the first.
REQ-033 Fairness: all valid, data = 16'h1111*(k+1) -> grant order 0,1,2,3,0 with o_disp_data sequence 1111, 2222, 3333, 4444, 1111, spaced 5 cycles apart.
REQ-034 Late arrival: req2 rises during HOLD of req0 -> no ready until IDLE, then requester 2 is granted before requester 0 (round-robin).
REQ-035 Withdrawn request: req3 valid for one cycle during HOLD, then low -> no transfer; display unchanged.
REQ-036 HOLD_CYCLES=1: continuous req0 -> transfers every 2 cycles; o_busy toggles 1,0.
